// File: rtl/ysyx_24100005_lsu.sv
`default_nettype none
// ============================================================================
// ysyx_24100005_lsu : multi-cycle load/store unit with lane steering,
// sign/zero extension, misalignment check and memory timeout.
// Revision: 1.0
// ============================================================================
module ysyx_24100005_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OB    = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic            st_store;
    logic [2:0]      st_funct3;
    logic [OB-1:0]   st_off;
    logic [CNT_W-1:0] cnt;

    logic [OB-1:0]   req_off;
    logic            legal;
    logic            misaligned;
    logic [XLEN-1:0] wdata_lanes;
    logic [NB-1:0]   wmask_lanes;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] rd_ext;

    assign req_off = req_addr[OB-1:0];

    always_comb begin
        legal = 1'b0;
        if (req_store) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (XLEN == 64);
                default:                legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (XLEN == 64);
                default:                                legal = 1'b0;
            endcase
        end
    end

    // funct3[1:0] encodes the access size for every legal load and store
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        wdata_lanes = '0;
        wmask_lanes = '0;
        case (req_funct3[1:0])
            2'b00: begin
                wdata_lanes = {NB{req_wdata[7:0]}};
                wmask_lanes = NB'(1);
            end
            2'b01: begin
                wdata_lanes = {(NB/2){req_wdata[15:0]}};
                wmask_lanes = NB'(3);
            end
            2'b10: begin
                wdata_lanes = {(NB/4){req_wdata[31:0]}};
                wmask_lanes = NB'(15);
            end
            default: begin
                wdata_lanes = req_wdata;
                wmask_lanes = '1;
            end
        endcase
        wdata_lanes = wdata_lanes << {req_off, 3'b000};
        wmask_lanes = wmask_lanes << req_off;
    end

    assign rd_shift = mem_rdata >> {st_off, 3'b000};

    // Fill the whole word first, then overwrite the access-sized low part
    always_comb begin
        rd_ext = rd_shift;
        case (st_funct3)
            3'b000: begin rd_ext = {XLEN{rd_shift[7]}};  rd_ext[7:0]  = rd_shift[7:0];  end
            3'b001: begin rd_ext = {XLEN{rd_shift[15]}}; rd_ext[15:0] = rd_shift[15:0]; end
            3'b010: begin rd_ext = {XLEN{rd_shift[31]}}; rd_ext[31:0] = rd_shift[31:0]; end
            3'b100: begin rd_ext = '0; rd_ext[7:0]  = rd_shift[7:0];  end
            3'b101: begin rd_ext = '0; rd_ext[15:0] = rd_shift[15:0]; end
            3'b110: begin rd_ext = '0; rd_ext[31:0] = rd_shift[31:0]; end
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 2'b00;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            st_store      <= 1'b0;
            st_funct3     <= 3'b000;
            st_off        <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        st_store   <= req_store;
                        st_funct3  <= req_funct3;
                        st_off     <= req_off;
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        if (!legal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 2'b11;
                        end else if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 2'b01;
                        end else begin
                            state         <= MREQ;
                            resp_err      <= 2'b00;
                            mem_req_valid <= 1'b1;
                            mem_we        <= req_store;
                            mem_addr      <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                            mem_wdata     <= req_store ? wdata_lanes : '0;
                            mem_wmask     <= req_store ? wmask_lanes : '0;
                        end
                    end
                end
                MREQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= MWAIT;
                    end
                end
                MWAIT: begin
                    // A response on the final counted cycle still wins over the timeout
                    if (mem_rsp_valid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b00;
                        if (!st_store) resp_rdata <= rd_ext;
                        mem_we     <= 1'b0;
                        mem_wmask  <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b10;
                        mem_we     <= 1'b0;
                        mem_wmask  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 2'b00;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_lsu.sv
`default_nettype none
// ============================================================================
// tb_ysyx_24100005_lsu : directed self-checking bench for the load/store unit.
// Revision: 1.0
// ============================================================================
module tb_ysyx_24100005_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Drives one access against a zero-wait memory and reports what it saw.
    task automatic run_access(
        input  logic st, input logic [2:0] f3, input logic [31:0] a,
        input  logic [31:0] wd, input logic [31:0] rd,
        output logic got, output int lat, output logic seen_req,
        output logic [31:0] c_addr, output logic [31:0] c_wdata,
        output logic [3:0] c_mask, output logic c_we,
        output logic [31:0] g_rdata, output logic [1:0] g_err);
        logic hs;
        got = 0; lat = 0; seen_req = 0; hs = 0;
        c_addr = '0; c_wdata = '0; c_mask = '0; c_we = 0; g_rdata = '0; g_err = '0;
        req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            req_valid     = 0;
            mem_rsp_valid = hs;
            mem_rdata     = rd;
            hs            = 0;
            mem_req_ready = 0;
            if (mem_req_valid) begin
                seen_req = 1; c_addr = mem_addr; c_wdata = mem_wdata;
                c_mask = mem_wmask; c_we = mem_we;
                mem_req_ready = 1; hs = 1;
            end
            if (resp_valid) begin
                got = 1; lat = i; g_rdata = resp_rdata; g_err = resp_err;
                mem_rsp_valid = 0;
                resp_ready = 1;
                tick();
                resp_ready = 0;
            end
        end
        mem_rsp_valid = 0;
        mem_req_ready = 0;
    endtask

    task automatic test_reset;
        rst = 1; tick(); tick(); rst = 0;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (mem_req_valid !== 1'b0 || mem_we !== 1'b0 || mem_wmask !== 4'h0)
            begin n_err++; $display("FAIL reset_mem: got v=%b we=%b m=%h expected 0/0/0", mem_req_valid, mem_we, mem_wmask); end
        n_cmp++; if (resp_err !== 2'b00 || resp_rdata !== 32'h0)
            begin n_err++; $display("FAIL reset_resp: got err=%b rdata=%h expected 00/0", resp_err, resp_rdata); end
    endtask

    task automatic test_lw;
        logic got, seen, we; int lat; logic [31:0] ca, cw, rd; logic [3:0] cm; logic [1:0] er;
        run_access(0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL lw_resp_timeout: got %b expected 1", got); end
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL lw_latency: got %0d expected 3", lat); end
        n_cmp++; if (ca !== 32'h8000_0004 || cm !== 4'h0 || we !== 1'b0)
            begin n_err++; $display("FAIL lw_mem_req: got a=%h m=%h we=%b expected 80000004/0/0", ca, cm, we); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF || er !== 2'b00)
            begin n_err++; $display("FAIL lw_resp: got %h/%b expected deadbeef/00", rd, er); end
        n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            begin n_err++; $display("FAIL lw_back_idle: got rdy=%b rv=%b expected 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_byte_half_loads;
        logic got, seen, we; int lat; logic [31:0] ca, cw, rd; logic [3:0] cm; logic [1:0] er;
        run_access(0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (rd !== 32'hFFFF_FF80 || er !== 2'b00 || ca !== 32'h8000_0000)
            begin n_err++; $display("FAIL lb: got %h/%b a=%h expected ffffff80/00/80000000", rd, er, ca); end
        run_access(0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (rd !== 32'h0000_0080 || er !== 2'b00)
            begin n_err++; $display("FAIL lbu: got %h/%b expected 00000080/00", rd, er); end
        run_access(0, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_0000, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (rd !== 32'hFFFF_80FF) begin n_err++; $display("FAIL lh: got %h expected ffff80ff", rd); end
        run_access(0, 3'b101, 32'h8000_0002, 32'h0, 32'h80FF_0000, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (rd !== 32'h0000_80FF) begin n_err++; $display("FAIL lhu: got %h expected 000080ff", rd); end
        run_access(0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_7F00, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (rd !== 32'h0000_007F) begin n_err++; $display("FAIL lb_pos: got %h expected 0000007f", rd); end
    endtask

    task automatic test_stores;
        logic got, seen, we; int lat; logic [31:0] ca, cw, rd; logic [3:0] cm; logic [1:0] er;
        run_access(1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (ca !== 32'h8000_0000 || cm !== 4'b1100 || we !== 1'b1)
            begin n_err++; $display("FAIL sh_req: got a=%h m=%b we=%b expected 80000000/1100/1", ca, cm, we); end
        n_cmp++; if (cw[31:16] !== 16'hABCD) begin n_err++; $display("FAIL sh_wdata: got %h expected abcd", cw[31:16]); end
        n_cmp++; if (rd !== 32'h0 || er !== 2'b00 || lat != 3)
            begin n_err++; $display("FAIL sh_resp: got %h/%b lat=%0d expected 0/00/3", rd, er, lat); end
        run_access(1, 3'b000, 32'h8000_0001, 32'h0000_0055, 32'h0, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (cm !== 4'b0010 || cw[15:8] !== 8'h55)
            begin n_err++; $display("FAIL sb: got m=%b d=%h expected 0010/55", cm, cw[15:8]); end
        run_access(1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (ca !== 32'h8000_0008 || cm !== 4'hF || cw !== 32'hCAFE_F00D)
            begin n_err++; $display("FAIL sw: got a=%h m=%h d=%h expected 80000008/f/cafef00d", ca, cm, cw); end
    endtask

    task automatic test_errors;
        logic got, seen, we; int lat; logic [31:0] ca, cw, rd; logic [3:0] cm; logic [1:0] er;
        run_access(0, 3'b010, 32'h8000_0001, 32'h0, 32'h1111_1111, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (seen !== 1'b0 || er !== 2'b01 || lat != 1 || rd !== 32'h0)
            begin n_err++; $display("FAIL lw_misaligned: got seen=%b err=%b lat=%0d rd=%h expected 0/01/1/0", seen, er, lat, rd); end
        run_access(1, 3'b001, 32'h8000_0003, 32'h0, 32'h0, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (seen !== 1'b0 || er !== 2'b01)
            begin n_err++; $display("FAIL sh_misaligned: got seen=%b err=%b expected 0/01", seen, er); end
        run_access(0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (seen !== 1'b0 || er !== 2'b11 || lat != 1)
            begin n_err++; $display("FAIL ld_illegal: got seen=%b err=%b lat=%0d expected 0/11/1", seen, er, lat); end
        run_access(1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (er !== 2'b11) begin n_err++; $display("FAIL store_illegal: got %b expected 11", er); end
        run_access(0, 3'b110, 32'h8000_0001, 32'h0, 32'h0, got, lat, seen, ca, cw, cm, we, rd, er);
        n_cmp++; if (er !== 2'b11) begin n_err++; $display("FAIL lwu_illegal_prio: got %b expected 11", er); end
    endtask

    task automatic test_timeout;
        logic stable; int n;
        req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
        mem_req_ready = 0;
        tick(); req_valid = 0;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0010 || mem_we !== 1'b0) stable = 0;
            tick();
        end
        n_cmp++; if (stable !== 1'b1 || mem_req_valid !== 1'b1 || resp_valid !== 1'b0)
            begin n_err++; $display("FAIL mreq_hold: got stable=%b v=%b expected 1/1", stable, mem_req_valid); end
        mem_req_ready = 1;
        tick(); mem_req_ready = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid === 1'b1) break;
            n++;
            tick();
        end
        n_cmp++; if (n != 8) begin n_err++; $display("FAIL mwait_cycles: got %0d expected 8", n); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 2'b10 || resp_rdata !== 32'h0)
            begin n_err++; $display("FAIL timeout_resp: got v=%b err=%b rd=%h expected 1/10/0", resp_valid, resp_err, resp_rdata); end
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_err !== 2'b10 || resp_rdata !== 32'h0 || req_ready !== 1'b0) stable = 0;
        end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL resp_hold: got stable=%b expected 1", stable); end
        resp_ready = 1; tick(); resp_ready = 0;
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            begin n_err++; $display("FAIL timeout_release: got rv=%b rdy=%b expected 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_timeout_edge;
        logic early;
        req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0020;
        mem_req_ready = 1;
        tick(); req_valid = 0;
        tick(); mem_req_ready = 0;
        early = 0;
        for (int i = 0; i < 7; i++) begin
            if (resp_valid !== 1'b0) early = 1;
            tick();
        end
        mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
        tick(); mem_rsp_valid = 0;
        n_cmp++; if (early !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 2'b00 || resp_rdata !== 32'h1234_5678)
            begin n_err++; $display("FAIL rsp_at_timeout: got early=%b v=%b err=%b rd=%h expected 0/1/00/12345678", early, resp_valid, resp_err, resp_rdata); end
        resp_ready = 1; tick(); resp_ready = 0;
    endtask

    task automatic test_reset_in_mwait;
        req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0030;
        mem_req_ready = 1;
        tick(); req_valid = 0;
        tick(); mem_req_ready = 0;
        tick();
        rst = 1; tick(); rst = 0;
        mem_rsp_valid = 1; mem_rdata = 32'hAAAA_5555;
        n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
            begin n_err++; $display("FAIL rst_abort: got rdy=%b rv=%b mv=%b expected 1/0/0", req_ready, resp_valid, mem_req_valid); end
        tick(); mem_rsp_valid = 0;
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0)
            begin n_err++; $display("FAIL stray_rsp: got rv=%b rdy=%b rd=%h expected 0/1/0", resp_valid, req_ready, resp_rdata); end
        tick();
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL stray_rsp_late: got %b expected 0", resp_valid); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_half_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_timeout_edge();
        test_reset_in_mwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
